// File: rtl/sdhv_am_search_ctrl.sv
// rtl/sdhv_am_search_ctrl.sv - associative-memory argmax search over stored class hypervectors
// Sequences fetch, similarity and best-score tracking per class, then holds the winner until taken.
module sdhv_am_search_ctrl #(
   parameter int LENGTH_VECTOR = 32,
   parameter int NUM_CLASSES   = 8,
   parameter int SCORE_W       = $clog2(LENGTH_VECTOR) + 1,
   parameter int IDX_W         = $clog2(NUM_CLASSES)
) (
   input  logic                     clk,
   input  logic                     arst_n_in,
   input  logic                     query_valid,
   output logic                     query_ready,
   input  logic [LENGTH_VECTOR-1:0] query_hv,
   output logic                     mem_rd_en,
   output logic [IDX_W-1:0]         mem_addr,
   input  logic [LENGTH_VECTOR-1:0] mem_rdata,
   output logic                     sim_start,
   output logic [LENGTH_VECTOR-1:0] sim_hv_a,
   output logic [LENGTH_VECTOR-1:0] sim_hv_b,
   input  logic                     sim_done,
   input  logic [SCORE_W-1:0]       sim_count,
   output logic                     result_valid,
   input  logic                     result_ready,
   output logic [IDX_W-1:0]         result_idx,
   output logic [SCORE_W-1:0]       result_score,
   output logic                     busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_MEM_WAIT,
      S_START,
      S_RUN,
      S_UPDATE,
      S_RESULT
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   state_t                     state_q;
   state_t                     state_d;
   logic [LENGTH_VECTOR-1:0]   query_q;
   logic [LENGTH_VECTOR-1:0]   class_q;
   logic [IDX_W-1:0]           cls_idx;
   logic [IDX_W-1:0]           best_idx;
   logic [SCORE_W-1:0]         best_score;
   logic [SCORE_W-1:0]         count_q;

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      query_ready  = 1'b0;
      mem_rd_en    = 1'b0;
      sim_start    = 1'b0;
      result_valid = 1'b0;
      busy         = 1'b1;
      case (state_q)
         S_IDLE: begin
            query_ready = 1'b1;
            busy        = 1'b0;
            if (query_valid) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            mem_rd_en = 1'b1;
            state_d   = S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            state_d = S_START;
         end
         S_START: begin
            sim_start = 1'b1;
            state_d   = S_RUN;
         end
         S_RUN: begin
            if (sim_done) begin
               state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            state_d = (cls_idx == LAST_IDX) ? S_RESULT : S_FETCH;
         end
         S_RESULT: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath registers; each is only written in the state that owns it.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         query_q    <= '0;
         class_q    <= '0;
         cls_idx    <= '0;
         best_idx   <= '0;
         best_score <= '0;
         count_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (query_valid) begin
                  query_q    <= query_hv;
                  cls_idx    <= '0;
                  best_idx   <= '0;
                  best_score <= '0;
               end
            end
            S_MEM_WAIT: begin
               class_q <= mem_rdata;
            end
            S_RUN: begin
               if (sim_done) begin
                  count_q <= sim_count;
               end
            end
            S_UPDATE: begin
               // Strictly greater keeps the lowest index on ties.
               if ((cls_idx == '0) || (count_q > best_score)) begin
                  best_score <= count_q;
                  best_idx   <= cls_idx;
               end
               if (cls_idx != LAST_IDX) begin
                  cls_idx <= cls_idx + IDX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_addr     = cls_idx;
   assign sim_hv_a     = query_q;
   assign sim_hv_b     = class_q;
   assign result_idx   = best_idx;
   assign result_score = best_score;

endmodule

// File: doc/sdhv_am_search_ctrl.md
Name: sdhv_am_search_ctrl

Overview:
- Associative-memory search controller for sparse binary HDC inference.
- Accepts one query hypervector, then for every stored class hypervector: reads it from class memory, runs the shared bit-serial similarity (overlap-count) unit on query vs class, and tracks the best score.
- Returns argmax class index and its score.
- Sits between the query encoder and the classifier output, and owns the similarity unit's start/done handshake.

Parameters:
- LENGTH_VECTOR, 32, hypervector width in bits.
- NUM_CLASSES, 8, number of stored class hypervectors; must be 2 or more.
- SCORE_W, $clog2(LENGTH_VECTOR)+1, width of similarity count; holds 0..LENGTH_VECTOR.
- IDX_W, $clog2(NUM_CLASSES), class index width.

Ports:
- clk  in  1  system clock, rising edge.
- arst_n_in  in  1  asynchronous, active-low reset.
- query_valid  in  1  query_hv is valid.
- query_ready  out  1  controller can accept a query; high only in IDLE.
- query_hv  in  LENGTH_VECTOR  query hypervector.
- mem_rd_en  out  1  class memory read strobe.
- mem_addr  out  IDX_W  class index to read.
- mem_rdata  in  LENGTH_VECTOR  class hypervector; valid exactly 1 cycle after mem_rd_en.
- sim_start  out  1  one-cycle start pulse to the similarity unit.
- sim_hv_a  out  LENGTH_VECTOR  operand A (latched query).
- sim_hv_b  out  LENGTH_VECTOR  operand B (latched class vector).
- sim_done  in  1  one-cycle done pulse from the similarity unit.
- sim_count  in  SCORE_W  overlap count; valid in the sim_done cycle.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- result_idx  out  IDX_W  best-matching class index.
- result_score  out  SCORE_W  best score.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset is asynchronous and active-low on arst_n_in.
  - State goes to IDLE.
  - All outputs are 0, except query_ready, which is 1 (IDLE).
  - Internal query register, class register, index, best_idx and best_score all clear to 0.
- FSM states: IDLE, FETCH, MEM_WAIT, START, RUN, UPDATE, RESULT.
- IDLE:
  - query_ready = 1.
  - On query_valid & query_ready: latch query_hv, set cls_idx = 0, best_score = 0, best_idx = 0, go to FETCH.
- FETCH:
  - mem_rd_en = 1 and mem_addr = cls_idx for this one cycle; go to MEM_WAIT.
  - mem_addr holds cls_idx in all other states and is not a don't-care.
- MEM_WAIT: latch mem_rdata into the class register; go to START.
- START:
  - sim_start = 1 for exactly one cycle; go to RUN.
  - sim_hv_a and sim_hv_b are registered and stable from START until leaving RUN.
- RUN:
  - Wait for sim_done, with no timeout.
  - On sim_done, capture sim_count and go to UPDATE.
  - A sim_done seen outside RUN is ignored.
- UPDATE:
  - If cls_idx == 0 or captured count > best_score: best_score = count and best_idx = cls_idx.
  - Comparison is strictly greater, so ties keep the lowest index.
  - If cls_idx == NUM_CLASSES-1, go to RESULT; otherwise increment cls_idx and go to FETCH.
- RESULT:
  - result_valid = 1 with result_idx = best_idx and result_score = best_score, held stable until result_ready.
  - On result_valid & result_ready: go to IDLE; result_valid drops the next cycle.
  - query_ready stays 0 until IDLE is re-entered, so no new query is accepted in the handshake cycle.
- Latency per class: 4 cycles (FETCH, MEM_WAIT, START, UPDATE) + RUN cycles (sim latency).
  - Total from query accept to result_valid = NUM_CLASSES × (4 + sim latency) cycles.
- Arithmetic: scores are unsigned SCORE_W; there is no overflow, since the maximum is LENGTH_VECTOR.
- Reset mid-search: immediate return to IDLE with all registers cleared, and no result is produced.
  - sim_start is not reissued; the similarity unit is on the same reset.
- query_valid asserted while busy: ignored and not queued (query_ready = 0).

Test Plan:
- Single search, NUM_CLASSES=4, LENGTH_VECTOR=32:
  - Stimulus: query=0xF0F0_0000; classes = 0x0000_000F (score 0), 0xF000_0000 (4), 0xF0F0_0000 (8), 0x00F0_0000 (4).
  - Required: result_idx=2, result_score=8; exactly 4 sim_start pulses; mem_addr sequence 0,1,2,3.
- Tie-break:
  - Stimulus: classes 1 and 3 both score 6, all others lower.
  - Required: result_idx=1, result_score=6.
- All-zero scores:
  - Stimulus: query=0x0000_0000.
  - Required: result_idx=0, result_score=0.
- Backpressure:
  - Stimulus: hold result_ready=0 for 10 cycles; pulse query_valid meanwhile.
  - Required: result_valid and result fields stable all 10 cycles; query_ready=0 and the query is ignored; IDLE is entered only after result_ready.
- Timing, with a bench similarity model of fixed 33-cycle latency:
  - Required: result_valid asserts exactly 4×(4+33)=148 cycles after query accept; sim_hv_a/b unchanged from sim_start through sim_done.
- Reset mid-operation:
  - Stimulus: drop arst_n_in during RUN of class 2.
  - Required: outputs go to their reset values asynchronously; after release, query_ready=1, no result_valid; a new query completes correctly.
